cnt_sched: RTL and testbench

Round-robin scheduler that shares one 4-bit up-counter core between NREQ requesters, each asking for a timed interval of 1–16 ticks. It grants the counter to one requester at a time and sequences the core through clear, count and terminal detection. It reports completion to the owning requester. It sits between the requesting agents and the counter core, and is the only driver of the core's enable and clear.

---
 rtl/cnt_sched.sv | 154 +++++++++++++++
 tb/tb_cnt_sched.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/cnt_sched.sv
// rtl/cnt_sched.sv - round-robin scheduler sharing one up-counter core among NREQ requesters
//
// Grants the shared counter core to one requester at a time. It sequences the
// core through clear, count and terminal detection, then pulses completion to
// the owner.
//
// Optional feature: define CNT_SCHED_ABORT_EN to add the abort input and the
// done_aborted output.
//
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   synchronous active-low reset
//   req_valid    in   [NREQ]     per-requester interval request
//   req_len      in   [NREQ*CW]  requested length, slice i = requester i, 0 means 16
//   req_ready    out  [NREQ]     one-hot accept, only in IDLE
//   cnt_clr      out  clear strobe to the counter core
//   cnt_en       out  count enable to the counter core
//   cnt_value    in   [CW]       current count from the core
//   busy         out  high whenever not IDLE
//   owner        out  [IDW]      current or last grant holder
//   done_valid   out  one-cycle completion pulse
//   done_id      out  [IDW]      id qualified by done_valid
//   abort        in   (CNT_SCHED_ABORT_EN) end the interval early
//   done_aborted out  (CNT_SCHED_ABORT_EN) completion was caused by abort
module cnt_sched #(
  parameter int NREQ = 4,
  parameter int CW   = 4,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*CW-1:0] req_len,
  output logic [NREQ-1:0]    req_ready,
  output logic               cnt_clr,
  output logic               cnt_en,
  input  logic [CW-1:0]      cnt_value,
  output logic               busy,
  output logic [IDW-1:0]     owner,
  output logic               done_valid,
  output logic [IDW-1:0]     done_id
`ifdef CNT_SCHED_ABORT_EN
  ,
  input  logic               abort,
  output logic               done_aborted
`endif
);

  typedef enum logic [1:0] {IDLE, CLR, RUN, DONE} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] last_grant;
  logic [CW-1:0]  len_m1;
  logic [IDW-1:0] winner;
  logic [IDW-1:0] idx;
  logic           found;
  logic [CW-1:0]  sel_len;
  logic           abort_in;
`ifdef CNT_SCHED_ABORT_EN
  logic           aborted;
  assign abort_in = abort;
`else
  assign abort_in = 1'b0;
`endif

  // Round-robin search starting one past the last grant holder.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IDW'((int'(last_grant) + k) % NREQ);
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
    sel_len = req_len[int'(winner)*CW +: CW];
  end

  assign busy = (state != IDLE);

  always_comb begin
    state_nxt  = state;
    req_ready  = '0;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    done_valid = 1'b0;
    done_id    = '0;
    case (state)
      IDLE: begin
        if (found) begin
          req_ready[winner] = 1'b1;
          state_nxt         = CLR;
        end
      end
      CLR: begin
        cnt_clr   = 1'b1;
        state_nxt = abort_in ? DONE : RUN;
      end
      RUN: begin
        if (abort_in) begin
          state_nxt = DONE;
        end else begin
          cnt_en = 1'b1;
          if (cnt_value == len_m1) state_nxt = DONE;
        end
      end
      DONE: begin
        done_valid = 1'b1;
        done_id    = owner;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Keep the core and requesters quiet while reset is held, so an aborted
    // interval stops counting at once.
    if (!rst_n) begin
      req_ready  = '0;
      cnt_clr    = 1'b0;
      cnt_en     = 1'b0;
      done_valid = 1'b0;
      done_id    = '0;
    end
  end

`ifdef CNT_SCHED_ABORT_EN
  assign done_aborted = (state == DONE) && aborted && rst_n;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= IDW'(NREQ - 1);
      owner      <= '0;
      len_m1     <= '0;
`ifdef CNT_SCHED_ABORT_EN
      aborted    <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (state == IDLE && found) begin
        owner  <= winner;
        len_m1 <= sel_len - CW'(1);
      end
      if (state == DONE) last_grant <= owner;
`ifdef CNT_SCHED_ABORT_EN
      // Only an abort taken in CLR/RUN leads into DONE with this flag set.
      aborted <= abort_in && (state == CLR || state == RUN);
`endif
    end
  end

endmodule

// File: tb/tb_cnt_sched.sv
// tb/tb_cnt_sched.sv - directed self-checking bench for cnt_sched
module tb_cnt_sched;
  localparam int NREQ = 4;
  localparam int CW   = 4;

  logic               clk;
  logic               rst_n;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*CW-1:0] req_len;
  logic [NREQ-1:0]    req_ready;
  logic               cnt_clr;
  logic               cnt_en;
  logic [CW-1:0]      cnt_value;
  logic               busy;
  logic [1:0]         owner;
  logic               done_valid;
  logic [1:0]         done_id;
`ifdef CNT_SCHED_ABORT_EN
  logic               abort;
  logic               done_aborted;
`endif

  int   checks = 0;
  int   errors = 0;
  int   viol = 0;
  logic prev_done = 1'b0;

  cnt_sched #(.NREQ(NREQ), .CW(CW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_len(req_len),
    .req_ready(req_ready),
    .cnt_clr(cnt_clr),
    .cnt_en(cnt_en),
    .cnt_value(cnt_value),
    .busy(busy),
    .owner(owner),
    .done_valid(done_valid),
    .done_id(done_id)
`ifdef CNT_SCHED_ABORT_EN
    ,
    .abort(abort),
    .done_aborted(done_aborted)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counter core model
  always @(posedge clk) begin
    if (!rst_n || cnt_clr) cnt_value <= '0;
    else if (cnt_en) cnt_value <= cnt_value + 4'd1;
  end

  // Protocol invariants: one-hot ready, no back-to-back done pulses
  always @(negedge clk) begin
    if (!$onehot0(req_ready)) viol++;
    if (done_valid && prev_done) viol++;
    prev_done = done_valid;
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_done(input int max, output int cyc, output int ens,
                           output logic saw15, output logic seen);
    cyc = 0; ens = 0; saw15 = 1'b0; seen = 1'b0;
    while (!seen && cyc < max) begin
      @(negedge clk);
      cyc++;
      if (cnt_en) ens++;
      if (cnt_en && cnt_value == 4'd15) saw15 = 1'b1;
      if (done_valid) seen = 1'b1;
    end
  endtask

  int   cyc, ens;
  logic saw15, seen;

  initial begin
    rst_n = 1'b0; req_valid = '0; req_len = '0;
`ifdef CNT_SCHED_ABORT_EN
    abort = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_en", cnt_en, 0);
    chk("rst_clr", cnt_clr, 0);
    chk("rst_done", done_valid, 0);
    chk("rst_owner", owner, 0);
    chk("rst_done_id", done_id, 0);
`ifdef CNT_SCHED_ABORT_EN
    chk("rst_aborted", done_aborted, 0);
`endif

    // Requester 0, len 3
    rst_n = 1'b1; req_valid = 4'b0001; req_len[3:0] = 4'd3;
    #1 chk("t1_ready", req_ready, 1);
    @(negedge clk);
    req_valid = '0;
    chk("t1_clr", cnt_clr, 1);
    chk("t1_busy", busy, 1);
    chk("t1_owner", owner, 0);
    chk("t1_ready_busy", req_ready, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t1_en", cnt_en, 1);
    end
    @(negedge clk);
    chk("t1_done", done_valid, 1);
    chk("t1_done_id", done_id, 0);
    chk("t1_en_off", cnt_en, 0);
    chk("t1_count", cnt_value, 3);
    @(negedge clk);
    chk("t1_idle", busy, 0);

    // Requester 1, len 0 -> 16 ticks with wrap
    req_valid = 4'b0010; req_len[7:4] = 4'd0;
    #1 chk("t2_ready", req_ready, 2);
    @(negedge clk);
    req_valid = '0;
    wait_done(40, cyc, ens, saw15, seen);
    chk("t2_seen", seen, 1);
    chk("t2_latency", cyc + 1, 18);
    chk("t2_en_cycles", ens, 16);
    chk("t2_saw15", saw15, 1);
    chk("t2_wrap", cnt_value, 0);
    chk("t2_done_id", done_id, 1);
    @(negedge clk);

    // Requester 2, len 5, req_len changed to 9 mid-run
    req_valid = 4'b0100; req_len[11:8] = 4'd5;
    #1 chk("t3_ready", req_ready, 4);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    chk("t3_en_a", cnt_en, 1);
    @(negedge clk);
    chk("t3_en_b", cnt_en, 1);
    req_len[11:8] = 4'd9;
    wait_done(30, cyc, ens, saw15, seen);
    chk("t3_seen", seen, 1);
    chk("t3_latency", cyc + 3, 7);
    chk("t3_en_cycles", ens + 2, 5);
    chk("t3_done_id", done_id, 2);
    @(negedge clk);

    // Requester 3, len 8, reset during RUN
    req_valid = 4'b1000; req_len[15:12] = 4'd8;
    #1 chk("t4_ready", req_ready, 8);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    chk("t4_en", cnt_en, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("t4_busy", busy, 0);
    chk("t4_en_off", cnt_en, 0);
    chk("t4_owner", owner, 0);
    wait_done(6, cyc, ens, saw15, seen);
    chk("t4_no_done", seen, 0);

    // All requesters, len 1: rotation 0,1,2,3,0 starting from reset
    req_valid = 4'b1111; req_len = 16'h1111;
    for (int g = 0; g < 5; g++) begin
      #1 chk("t5_ready", req_ready, 1 << (g % 4));
      @(negedge clk);
      chk("t5_owner", owner, g % 4);
      chk("t5_clr", cnt_clr, 1);
      @(negedge clk);
      chk("t5_en", cnt_en, 1);
      @(negedge clk);
      chk("t5_done", done_valid, 1);
      chk("t5_done_id", done_id, g % 4);
      @(negedge clk);
    end
    req_valid = '0;
    @(negedge clk);

`ifdef CNT_SCHED_ABORT_EN
    // Requester 0, len 10, abort on third RUN cycle
    req_valid = 4'b0001; req_len = 16'h000A;
    #1 chk("t6_ready", req_ready, 1);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    chk("t6_en_a", cnt_en, 1);
    @(negedge clk);
    chk("t6_en_b", cnt_en, 1);
    @(negedge clk);
    abort = 1'b1;
    #1 chk("t6_en_abort", cnt_en, 0);
    @(negedge clk);
    abort = 1'b0;
    chk("t6_done", done_valid, 1);
    chk("t6_aborted", done_aborted, 1);
    chk("t6_count", cnt_value, 2);
    @(negedge clk);
    chk("t6_aborted_clr", done_aborted, 0);
`endif

    chk("protocol", viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
